// File: rtl/mips_mc_control.sv
// mips_mc_control: multicycle MIPS control FSM with memory handshake and wait timeout.
// Define MIPS_MC_PERF_EN to build the instret/cycles performance counters.
module mips_mc_control #(
  parameter int ALUCTRL_W  = 4,
  parameter int WAIT_LIMIT = 15,
  parameter int CNT_W      = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [5:0]           op_i,
  input  logic [5:0]           funct_i,
  input  logic                 zero_i,
  input  logic                 mem_ready_i,
  output logic                 mem_req_o,
  output logic                 iord_o,
  output logic                 memwrite_o,
  output logic                 irwrite_o,
  output logic                 pcen_o,
  output logic [1:0]           pcsrc_o,
  output logic                 alusrca_o,
  output logic [1:0]           alusrcb_o,
  output logic [ALUCTRL_W-1:0] alucontrol_o,
  output logic                 regdst_o,
  output logic                 memtoreg_o,
  output logic                 regwrite_o,
  output logic                 halted_o,
  output logic [1:0]           err_code_o,
  output logic [CNT_W-1:0]     instret_o,
  output logic [CNT_W-1:0]     cycles_o
);
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J = 6'b000010, FN_JR = 6'b001000;
  localparam int CW = $clog2(WAIT_LIMIT + 2);
  localparam logic [CW-1:0] LIM = CW'(WAIT_LIMIT);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB,
    JR, BRANCH, ADDIEX, ADDIWB, JUMP, HALT
  } state_e;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [1:0] err_q, err_d;
  logic [3:0] fn_alu;
  logic mem_st, tmo, fn_ok;
  assign fn_alu = funct_i == 6'b100000 ? 4'b0010 :
                  funct_i == 6'b100010 ? 4'b0110 :
                  funct_i == 6'b100100 ? 4'b0000 :
                  funct_i == 6'b100101 ? 4'b0001 :
                  funct_i == 6'b101010 ? 4'b0111 :
                  funct_i == 6'b100111 ? 4'b1100 : 4'b0010;
  assign fn_ok = funct_i inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111};
  assign cnt_inc = cnt_q + 1'b1;
  assign mem_st = state_q inside {FETCH, MEMRD, MEMWR};
  // Limit reached means this is the WAIT_LIMIT-th cycle without mem_ready
  assign tmo = (WAIT_LIMIT != 0) && !mem_ready_i && cnt_inc == LIM;
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:   state_d = mem_ready_i ? DECODE : tmo ? HALT : FETCH;
      DECODE:  state_d = (op_i == OP_LW || op_i == OP_SW) ? MEMADR :
                         op_i == OP_R ? (funct_i == FN_JR ? JR : RTYPEEX) :
                         (op_i == OP_BEQ || op_i == OP_BNE) ? BRANCH :
                         op_i == OP_ADDI ? ADDIEX :
                         op_i == OP_J ? JUMP : HALT;
      MEMADR:  state_d = op_i == OP_SW ? MEMWR : MEMRD;
      MEMRD:   state_d = mem_ready_i ? MEMWB : tmo ? HALT : MEMRD;
      MEMWR:   state_d = mem_ready_i ? FETCH : tmo ? HALT : MEMWR;
      RTYPEEX: state_d = fn_ok ? RTYPEWB : HALT;
      ADDIEX:  state_d = ADDIWB;
      MEMWB, RTYPEWB, JR, BRANCH, ADDIWB, JUMP: state_d = FETCH;
      default: state_d = HALT;
    endcase
    err_d = (state_d == HALT && state_q != HALT) ? (mem_st ? 2'b10 : 2'b01) : err_q;
    cnt_d = state_d != state_q ? '0 : (mem_st && !mem_ready_i) ? cnt_inc : cnt_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= FETCH;
      cnt_q   <= '0;
      err_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end
  // Strobes are gated by reset so an access is dropped the instant reset asserts
  assign mem_req_o  = rst_ni && mem_st;
  assign memwrite_o = rst_ni && state_q == MEMWR;
  assign irwrite_o  = rst_ni && state_q == FETCH && mem_ready_i;
  assign regwrite_o = rst_ni && state_q inside {MEMWB, RTYPEWB, ADDIWB};
  assign pcen_o     = rst_ni && ((state_q == FETCH && mem_ready_i) || state_q inside {JR, JUMP} ||
                      (state_q == BRANCH && (op_i == OP_BEQ ? zero_i : !zero_i)));
  assign iord_o       = state_q inside {MEMRD, MEMWR};
  assign pcsrc_o      = state_q == JR ? 2'b11 : state_q == JUMP ? 2'b10 : state_q == BRANCH ? 2'b01 : 2'b00;
  assign alusrca_o    = state_q inside {MEMADR, RTYPEEX, BRANCH, ADDIEX};
  assign alusrcb_o    = state_q == FETCH ? 2'b01 : state_q == DECODE ? 2'b11 :
                        state_q inside {MEMADR, ADDIEX} ? 2'b10 : 2'b00;
  assign alucontrol_o = ALUCTRL_W'(state_q == RTYPEEX ? fn_alu : state_q == BRANCH ? 4'b0110 : 4'b0010);
  assign regdst_o     = state_q == RTYPEWB;
  assign memtoreg_o   = state_q == MEMWB;
  assign halted_o     = state_q == HALT;
  assign err_code_o   = err_q;
`ifdef MIPS_MC_PERF_EN
  logic [CNT_W-1:0] instret_q, cycles_q;
  logic retire;
  assign retire = state_d == FETCH && state_q inside {MEMWB, MEMWR, RTYPEWB, JR, BRANCH, ADDIWB, JUMP};
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      instret_q <= '0;
      cycles_q  <= '0;
    end else begin
      instret_q <= instret_q + CNT_W'(retire);
      cycles_q  <= cycles_q + CNT_W'(state_q != HALT);
    end
  end
  assign instret_o = instret_q;
  assign cycles_o  = cycles_q;
`else
  assign instret_o = '0;
  assign cycles_o  = '0;
`endif
endmodule

// File: tb/tb_mips_mc_control.sv
// tb_mips_mc_control: directed-vector bench for mips_mc_control (WAIT_LIMIT=4).
module tb_mips_mc_control;
  logic clk = 0, rst_n = 0, zero = 0, mem_ready = 1;
  logic [5:0] op = 0, funct = 0;
  logic mem_req, iord, memwrite, irwrite, pcen, alusrca, regdst, memtoreg, regwrite, halted;
  logic [1:0] pcsrc, alusrcb, err;
  logic [3:0] alucontrol;
  logic [31:0] instret, cycles;
  logic [17:0] sig;
  int total = 0, npass = 0;
  logic [17:0] S_RST, S_FETCH, S_FWAIT, S_DEC, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR;
  logic [17:0] S_RTEX_SLT, S_RTEX_ADD, S_RTWB, S_JR, S_BR_T, S_BR_F, S_ADDIEX, S_ADDIWB, S_JUMP, S_HALT;
  mips_mc_control #(.ALUCTRL_W(4), .WAIT_LIMIT(4), .CNT_W(32)) dut (
    .clk_i(clk), .rst_ni(rst_n), .op_i(op), .funct_i(funct), .zero_i(zero),
    .mem_ready_i(mem_ready), .mem_req_o(mem_req), .iord_o(iord), .memwrite_o(memwrite),
    .irwrite_o(irwrite), .pcen_o(pcen), .pcsrc_o(pcsrc), .alusrca_o(alusrca),
    .alusrcb_o(alusrcb), .alucontrol_o(alucontrol), .regdst_o(regdst),
    .memtoreg_o(memtoreg), .regwrite_o(regwrite), .halted_o(halted),
    .err_code_o(err), .instret_o(instret), .cycles_o(cycles)
  );
  assign sig = {mem_req, iord, memwrite, irwrite, pcen, pcsrc, alusrca, alusrcb,
                alucontrol, regdst, memtoreg, regwrite, halted};
  always #5 clk = ~clk;
  function automatic logic [17:0] s(input logic mr, io, mw, ir, pe, input logic [1:0] ps,
                                     input logic sa, input logic [1:0] sb, input logic [3:0] ac,
                                     input logic rd, mt, rw, h);
    return {mr, io, mw, ir, pe, ps, sa, sb, ac, rd, mt, rw, h};
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic fd(input string t, input logic [5:0] o, input logic [5:0] f);
    op = o;
    funct = f;
    mem_ready = 1;
    #1 chk({t, "_fetch"}, sig, S_FETCH);
    tick;
    chk({t, "_decode"}, sig, S_DEC);
    tick;
  endtask
  initial begin
    S_RST      = s(0,0,0,0,0,2'b00,0,2'b01,4'b0010,0,0,0,0);
    S_FETCH    = s(1,0,0,1,1,2'b00,0,2'b01,4'b0010,0,0,0,0);
    S_FWAIT    = s(1,0,0,0,0,2'b00,0,2'b01,4'b0010,0,0,0,0);
    S_DEC      = s(0,0,0,0,0,2'b00,0,2'b11,4'b0010,0,0,0,0);
    S_MEMADR   = s(0,0,0,0,0,2'b00,1,2'b10,4'b0010,0,0,0,0);
    S_MEMRD    = s(1,1,0,0,0,2'b00,0,2'b00,4'b0010,0,0,0,0);
    S_MEMWB    = s(0,0,0,0,0,2'b00,0,2'b00,4'b0010,0,1,1,0);
    S_MEMWR    = s(1,1,1,0,0,2'b00,0,2'b00,4'b0010,0,0,0,0);
    S_RTEX_SLT = s(0,0,0,0,0,2'b00,1,2'b00,4'b0111,0,0,0,0);
    S_RTEX_ADD = s(0,0,0,0,0,2'b00,1,2'b00,4'b0010,0,0,0,0);
    S_RTWB     = s(0,0,0,0,0,2'b00,0,2'b00,4'b0010,1,0,1,0);
    S_JR       = s(0,0,0,0,1,2'b11,0,2'b00,4'b0010,0,0,0,0);
    S_BR_T     = s(0,0,0,0,1,2'b01,1,2'b00,4'b0110,0,0,0,0);
    S_BR_F     = s(0,0,0,0,0,2'b01,1,2'b00,4'b0110,0,0,0,0);
    S_ADDIEX   = s(0,0,0,0,0,2'b00,1,2'b10,4'b0010,0,0,0,0);
    S_ADDIWB   = s(0,0,0,0,0,2'b00,0,2'b00,4'b0010,0,0,1,0);
    S_JUMP     = s(0,0,0,0,1,2'b10,0,2'b00,4'b0010,0,0,0,0);
    S_HALT     = s(0,0,0,0,0,2'b00,0,2'b00,4'b0010,0,0,0,1);
    #7 chk("rst_sig", sig, S_RST);
    chk("rst_err", err, 0);
    #5 rst_n = 1;
    fd("lw", 6'b100011, 6'b000000);
    chk("lw_memadr", sig, S_MEMADR); tick;
    chk("lw_memrd", sig, S_MEMRD); tick;
    chk("lw_memwb", sig, S_MEMWB); tick;
    fd("sw", 6'b101011, 6'b000000);
    chk("sw_memadr", sig, S_MEMADR); tick;
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3);
      #1 chk("sw_memwr", sig, S_MEMWR);
      tick;
    end
    chk("sw_err", err, 0);
    fd("bne", 6'b000101, 6'b000000);
    zero = 0; #1 chk("bne_z0", sig, S_BR_T);
    zero = 1; #1 chk("bne_z1", sig, S_BR_F);
    tick;
    fd("beq", 6'b000100, 6'b000000);
    zero = 0; #1 chk("beq_z0", sig, S_BR_F);
    zero = 1; #1 chk("beq_z1", sig, S_BR_T);
    tick;
    fd("slt", 6'b000000, 6'b101010);
    chk("slt_ex", sig, S_RTEX_SLT); tick;
    chk("slt_wb", sig, S_RTWB); tick;
    fd("jr", 6'b000000, 6'b001000);
    chk("jr", sig, S_JR); tick;
    fd("addi", 6'b001000, 6'b000000);
    chk("addi_ex", sig, S_ADDIEX); tick;
    chk("addi_wb", sig, S_ADDIWB); tick;
    fd("j", 6'b000010, 6'b000000);
    chk("j", sig, S_JUMP); tick;
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3);
      #1 chk("late_fetch", sig, i == 3 ? S_FETCH : S_FWAIT);
      tick;
    end
    chk("late_decode", sig, S_DEC);
    chk("late_err", err, 0);
    mem_ready = 1; tick;
    chk("late_jump", sig, S_JUMP); tick;
    fd("badfn", 6'b000000, 6'b111111);
    chk("badfn_ex", sig, S_RTEX_ADD); tick;
    chk("badfn_halt", sig, S_HALT);
    chk("badfn_err", err, 2'b01);
    #1 rst_n = 0;
    #1 chk("rst1_sig", sig, S_RST);
    chk("rst1_err", err, 0);
    #1 rst_n = 1;
    fd("badop", 6'b111111, 6'b000000);
    chk("badop_halt", sig, S_HALT);
    chk("badop_err", err, 2'b01);
    tick;
    chk("halt_stays", sig, S_HALT);
    #1 rst_n = 0;
    #1 chk("rst2_sig", sig, S_RST);
    chk("rst2_err", err, 0);
    #1 rst_n = 1;
    mem_ready = 0;
    for (int i = 0; i < 4; i++) begin
      #1 chk("tmo_wait", sig, S_FWAIT);
      tick;
    end
    chk("tmo_halt", sig, S_HALT);
    chk("tmo_err", err, 2'b10);
`ifndef MIPS_MC_PERF_EN
    chk("perf_cycles_off", cycles, 0);
    chk("perf_instret_off", instret, 0);
`endif
    $display("%0d/%0d checks passed", npass, total);
    $finish;
  end
endmodule
